// File: rtl/xsim_link_frame_rx.sv
// xsim_link_frame_rx: link rx word reassembler with store-and-forward frame buffer.
//
// Pops words from the link rx queue, parses a header (LEN in [15:0], CHAN in
// [31:16]) and stores LEN payload words in a circular buffer. Only committed
// frames are exposed on the out_* stream. Oversize frames are skipped and
// frames cut off by link loss are rolled back; both pulse frame_drop.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   link_up                  link connected indication
//   rx_first, rdy_rx_first   head word of the link rx queue and its valid
//   en_rx_deq                pop the link rx word this cycle (combinational)
//   out_data/out_chan/out_last/out_valid, out_ready   frame output stream
//   frame_done, frame_drop   one-cycle pulses on commit / drop
//
// Optional: define XSIM_LINK_FRAME_STATS_EN to add stat_frames / stat_drops.

module xsim_link_frame_rx #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAXLEN    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 link_up,
    input  logic [DATAWIDTH-1:0] rx_first,
    input  logic                 rdy_rx_first,
    output logic                 en_rx_deq,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [15:0]          out_chan,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic                 frame_drop
`ifdef XSIM_LINK_FRAME_STATS_EN
    ,
    output logic [31:0]          stat_frames,
    output logic [31:0]          stat_drops
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    chan_q, chan_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  commit_q, commit_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_drop_q, frame_drop_d;

    logic [DATAWIDTH-1:0] mem_data_q [DEPTH];
    logic [15:0]          mem_chan_q [DEPTH];
    logic                 mem_last_q [DEPTH];

    logic [PW-1:0]  used_c;
    logic           full_c;
    logic           wr_en_c;
    logic           pop_c;
    logic [15:0]    hdr_len_c;
    logic [15:0]    hdr_chan_c;

    assign hdr_len_c  = rx_first[15:0];
    assign hdr_chan_c = rx_first[31:16];
    assign used_c     = wr_q - rd_q;
    assign full_c     = (used_c == PW'(DEPTH));

    // No pop while held in reset; payload pops stall when the buffer is full.
    assign en_rx_deq = !RST && rdy_rx_first && link_up && ((state_q != ST_PAY) || !full_c);

    // Output stream reads committed entries only.
    assign out_valid = (rd_q != commit_q);
    assign out_data  = mem_data_q[rd_q[AW-1:0]];
    assign out_chan  = mem_chan_q[rd_q[AW-1:0]];
    assign out_last  = mem_last_q[rd_q[AW-1:0]];
    assign pop_c     = out_valid && out_ready;

    assign frame_done = frame_done_q;
    assign frame_drop = frame_drop_q;

    // Next-state and buffer-write control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chan_d       = chan_q;
        wr_d         = wr_q;
        commit_d     = commit_q;
        frame_done_d = 1'b0;
        frame_drop_d = 1'b0;
        wr_en_c      = 1'b0;
        rd_d         = rd_q + PW'(pop_c);

        case (state_q)
            ST_HDR: begin
                if (en_rx_deq) begin
                    if (hdr_len_c == 16'd0) begin
                        state_d = ST_HDR;
                    end else if (hdr_len_c > 16'(MAXLEN)) begin
                        frame_drop_d = 1'b1;
                        cnt_d        = hdr_len_c;
                        state_d      = ST_DROP;
                    end else begin
                        chan_d  = hdr_chan_c;
                        cnt_d   = hdr_len_c;
                        state_d = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (!link_up) begin
                    // Discard the partial frame; committed entries stay.
                    wr_d         = commit_q;
                    frame_drop_d = 1'b1;
                    state_d      = ST_HDR;
                end else if (en_rx_deq) begin
                    wr_en_c = 1'b1;
                    wr_d    = wr_q + PW'(1);
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        commit_d     = wr_q + PW'(1);
                        frame_done_d = 1'b1;
                        state_d      = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                if (!link_up) begin
                    state_d = ST_HDR;
                end else if (en_rx_deq) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // Control state and pointers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_HDR;
            cnt_q        <= 16'd0;
            chan_q       <= 16'd0;
            rd_q         <= '0;
            wr_q         <= '0;
            commit_q     <= '0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chan_q       <= chan_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            commit_q     <= commit_d;
            frame_done_q <= frame_done_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    // Payload storage; cleared on reset so the idle output reads zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data_q[i] <= '0;
                mem_chan_q[i] <= 16'd0;
                mem_last_q[i] <= 1'b0;
            end
        end else if (wr_en_c) begin
            mem_data_q[wr_q[AW-1:0]] <= rx_first;
            mem_chan_q[wr_q[AW-1:0]] <= chan_q;
            mem_last_q[wr_q[AW-1:0]] <= (cnt_q == 16'd1);
        end
    end

`ifdef XSIM_LINK_FRAME_STATS_EN
    logic [31:0] stat_frames_q;
    logic [31:0] stat_drops_q;

    // Event counters, wrapping at 2^32.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_frames_q <= 32'd0;
            stat_drops_q  <= 32'd0;
        end else begin
            stat_frames_q <= stat_frames_q + 32'(frame_done_q);
            stat_drops_q  <= stat_drops_q + 32'(frame_drop_q);
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_xsim_link_frame_rx.sv
// Directed bench for xsim_link_frame_rx (DATAWIDTH 32, DEPTH 16, MAXLEN 16).
module tb_xsim_link_frame_rx;

    logic        CLK = 1'b0;
    logic        RST;
    logic        link_up;
    logic [31:0] rx_first;
    logic        rdy_rx_first;
    logic        en_rx_deq;
    logic [31:0] out_data;
    logic [15:0] out_chan;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;
    logic        frame_drop;
`ifdef XSIM_LINK_FRAME_STATS_EN
    logic [31:0] stat_frames;
    logic [31:0] stat_drops;
`endif

    xsim_link_frame_rx #(
        .DATAWIDTH (32),
        .DEPTH     (16),
        .MAXLEN    (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .link_up      (link_up),
        .rx_first     (rx_first),
        .rdy_rx_first (rdy_rx_first),
        .en_rx_deq    (en_rx_deq),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_done   (frame_done),
        .frame_drop   (frame_drop)
`ifdef XSIM_LINK_FRAME_STATS_EN
        ,
        .stat_frames  (stat_frames),
        .stat_drops   (stat_drops)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_drop   = 0;
    int done_base;
    int drop_base;
    int rx_base  = 0;
    logic [63:0] rxq  [$];
    logic [63:0] expq [$];

    function automatic logic [63:0] ent(input logic [31:0] d, input logic [15:0] c, input logic l);
        return {15'd0, l, c, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output and pulse monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid && out_ready) rxq.push_back(ent(out_data, out_chan, out_last));
            if (frame_done) n_done++;
            if (frame_drop) n_drop++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Present one word and wait (bounded) until the DUT pops it.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        rx_first     = w;
        rdy_rx_first = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (en_rx_deq) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) check("send_timeout", 64'(en_rx_deq), 64'd1);
        rdy_rx_first = 1'b0;
    endtask

    task automatic exp_w(input logic [31:0] d, input logic [15:0] c, input logic l);
        expq.push_back(ent(d, c, l));
    endtask

    task automatic expect_rx(input string tag);
        check({tag, "_count"}, 64'(rxq.size() - rx_base), 64'(expq.size()));
        for (int i = 0; i < expq.size() && (rx_base + i) < rxq.size(); i++)
            check(tag, rxq[rx_base + i], expq[i]);
        rx_base = rxq.size();
        expq.delete();
    endtask

    task automatic mark_pulses();
        done_base = n_done;
        drop_base = n_drop;
    endtask

    task automatic expect_pulses(input string tag, input int d, input int p);
        check({tag, "_done"}, 64'(n_done - done_base), 64'(d));
        check({tag, "_drop"}, 64'(n_drop - drop_base), 64'(p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST          = 1'b1;
        link_up      = 1'b1;
        rx_first     = 32'h0001_0001;
        rdy_rx_first = 1'b1;
        out_ready    = 1'b0;
        #12;
        check("rst_en_rx_deq", 64'(en_rx_deq), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_chan",  64'(out_chan),  64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_drop", 64'(frame_drop), 64'd0);
        @(posedge CLK);
        #1;
        RST          = 1'b0;
        rdy_rx_first = 1'b0;
        idle(2);

        // Basic 2-word frame on channel 3.
        mark_pulses();
        out_ready = 1'b1;
        send_word(32'h0003_0002);
        send_word(32'h0000_000A);
        send_word(32'h0000_000B);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        check("t1_latency_data",  64'(out_data),  64'h0A);
        idle(5);
        exp_w(32'h0A, 16'd3, 1'b0);
        exp_w(32'h0B, 16'd3, 1'b1);
        expect_rx("t1");
        expect_pulses("t1", 1, 0);

        // Empty header is discarded silently.
        mark_pulses();
        send_word(32'h0009_0000);
        send_word(32'h0001_0001);
        send_word(32'h0000_0055);
        idle(5);
        exp_w(32'h55, 16'd1, 1'b1);
        expect_rx("t2");
        expect_pulses("t2", 1, 0);

        // Oversize frame (LEN 17) skipped, then a 1-word frame.
        mark_pulses();
        send_word(32'h0000_0011);
        for (int i = 0; i < 17; i++) send_word(32'hE000_0000 + 32'(i));
        send_word(32'h0004_0001);
        send_word(32'h0000_0033);
        idle(5);
        exp_w(32'h33, 16'd4, 1'b1);
        expect_rx("t3");
        expect_pulses("t3", 1, 1);

        // Backpressure: two 16-word frames with the consumer stalled.
        mark_pulses();
        out_ready = 1'b0;
        send_word(32'h000A_0010);
        for (int i = 0; i < 16; i++) send_word(32'h100 + 32'(i));
        send_word(32'h000B_0010);
        rx_first     = 32'h200;
        rdy_rx_first = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t4_stall_en", 64'(en_rx_deq), 64'd0);
        end
        check("t4_held_valid", 64'(out_valid), 64'd1);
        check("t4_held_data",  64'(out_data),  64'h100);
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_word(32'h200 + 32'(i));
        idle(40);
        for (int i = 0; i < 16; i++) exp_w(32'h100 + 32'(i), 16'd10, i == 15);
        for (int i = 0; i < 16; i++) exp_w(32'h200 + 32'(i), 16'd11, i == 15);
        expect_rx("t4");
        expect_pulses("t4", 2, 0);

        // Link loss mid-payload rolls back the partial frame.
        mark_pulses();
        send_word(32'h0007_0004);
        send_word(32'h0000_00C1);
        send_word(32'h0000_00C2);
        link_up = 1'b0;
        idle(3);
        check("t5_no_valid", 64'(out_valid), 64'd0);
        link_up = 1'b1;
        send_word(32'h0008_0001);
        send_word(32'h0000_0077);
        idle(5);
        exp_w(32'h77, 16'd8, 1'b1);
        expect_rx("t5");
        expect_pulses("t5", 1, 1);

        // Asynchronous reset mid-payload with a committed frame pending.
        mark_pulses();
        out_ready = 1'b0;
        send_word(32'h0002_0001);
        send_word(32'h0000_0011);
        check("t6_pending_valid", 64'(out_valid), 64'd1);
        send_word(32'h0002_0002);
        send_word(32'h0000_0021);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_data",  64'(out_data),  64'd0);
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        out_ready = 1'b1;
        idle(3);
        send_word(32'h0005_0001);
        send_word(32'h0000_0099);
        idle(5);
        exp_w(32'h99, 16'd5, 1'b1);
        expect_rx("t6");
        expect_pulses("t6", 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
